// File: rtl/expr_lane_pipe.sv
// expr_lane_pipe
//   Multi-lane expression evaluator. Each accepted beat carries LANES operand
//   pairs, per-lane signedness and one shared opcode. Results go through a
//   two-stage pipeline into a credit-managed output FIFO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready from registered state only)
//   in_op                 opcode shared by all lanes
//   in_sign               per-lane signed-operand select
//   in_a, in_b            lane i at bits [i*W +: W]
//   out_valid / out_ready output handshake
//   out_y, out_flag       head-of-FIFO lane results and flags
//   occupancy             FIFO entries plus beats in flight
module expr_lane_pipe #(
    parameter int W     = 6,
    parameter int LANES = 6,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [LANES-1:0]             in_sign,
    input  logic [LANES*W-1:0]           in_a,
    input  logic [LANES*W-1:0]           in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*W-1:0]           out_y,
    output logic [LANES-1:0]             out_flag,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int LW = LANES * W;
    localparam int SW = $clog2(W);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_XNOR = 3'd3,
        OP_SHL  = 3'd4,
        OP_SHR  = 3'd5,
        OP_LE   = 3'd6,
        OP_MUL  = 3'd7
    } op_e;

    // Returns {flag, y} for one lane.
    function automatic logic [W:0] f_lane(input op_e op, input logic s,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]     w_sum;
        logic [2*W-1:0] w_wide;
        logic [2*W-1:0] w_ax;
        logic [2*W-1:0] w_bx;
        logic [2*W-1:0] w_prod;
        logic [31:0]    w_amt;
        logic [W-1:0]   w_y;
        logic           w_f;
        w_sum  = '0;
        w_wide = '0;
        w_ax   = '0;
        w_bx   = '0;
        w_prod = '0;
        w_y    = '0;
        w_f    = 1'b0;
        w_amt  = 32'(b[SW-1:0]);
        case (op)
            OP_ADD: begin
                w_sum = {1'b0, a} + {1'b0, b};
                w_y   = w_sum[W-1:0];
                w_f   = s ? ((a[W-1] == b[W-1]) && (w_y[W-1] != a[W-1])) : w_sum[W];
            end
            OP_SUB: begin
                w_sum = {1'b0, a} - {1'b0, b};
                w_y   = w_sum[W-1:0];
                w_f   = s ? ((a[W-1] != b[W-1]) && (w_y[W-1] != a[W-1])) : w_sum[W];
            end
            OP_AND: begin
                w_y = a & b;
                w_f = (w_y == '0);
            end
            OP_XNOR: begin
                w_y = ~(a ^ b);
                w_f = (w_y == '0);
            end
            OP_SHL: begin
                if (w_amt >= W) begin
                    w_y = '0;
                    w_f = |a;
                end else begin
                    w_wide = {{W{1'b0}}, a} << w_amt;
                    w_y    = w_wide[W-1:0];
                    w_f    = |w_wide[2*W-1:W];
                end
            end
            OP_SHR: begin
                // Signed and unsigned shifts kept in separate branches so the
                // arithmetic shift is not demoted to a logical one.
                if (w_amt >= W) begin
                    w_y = s ? {W{a[W-1]}} : '0;
                end else if (s) begin
                    w_y = $signed(a) >>> w_amt;
                end else begin
                    w_y = a >> w_amt;
                end
                w_f = (w_y == '0);
            end
            OP_LE: begin
                if (s) begin
                    w_y = {{(W-1){1'b0}}, ($signed(a) <= $signed(b))};
                end else begin
                    w_y = {{(W-1){1'b0}}, (a <= b)};
                end
                w_f = (a == b);
            end
            default: begin
                w_ax   = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
                w_bx   = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
                w_prod = w_ax * w_bx;
                w_y    = w_prod[W-1:0];
                w_f    = s ? (w_prod[2*W-1:W] != {W{w_y[W-1]}}) : (w_prod[2*W-1:W] != '0);
            end
        endcase
        return {w_f, w_y};
    endfunction

    function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic              w_acc;
    logic              w_pop;
    logic              r_s1_v;
    op_e               r_s1_op;
    logic [LANES-1:0]  r_s1_sign;
    logic [LW-1:0]     r_s1_a;
    logic [LW-1:0]     r_s1_b;
    logic [LW-1:0]     w_res_y;
    logic [LANES-1:0]  w_res_f;
    logic              r_s2_v;
    logic [LW-1:0]     r_s2_y;
    logic [LANES-1:0]  r_s2_f;
    logic [LW-1:0]     r_mem_y [DEPTH];
    logic [LANES-1:0]  r_mem_f [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [OW-1:0]     r_cnt;
    logic [OW-1:0]     r_occ;

    assign in_ready  = (r_occ < OW'(DEPTH));
    assign out_valid = (r_cnt != '0);
    assign out_y     = r_mem_y[r_rd];
    assign out_flag  = r_mem_f[r_rd];
    assign occupancy = r_occ;
    assign w_acc     = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_res_y = '0;
        w_res_f = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            {w_res_f[i], w_res_y[i*W +: W]} =
                f_lane(r_s1_op, r_s1_sign[i], r_s1_a[i*W +: W], r_s1_b[i*W +: W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_op   <= OP_ADD;
            r_s1_sign <= '0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s2_v    <= 1'b0;
            r_s2_y    <= '0;
            r_s2_f    <= '0;
        end else begin
            r_s1_v <= w_acc;
            if (w_acc) begin
                r_s1_op   <= op_e'(in_op);
                r_s1_sign <= in_sign;
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
            end
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_y <= w_res_y;
                r_s2_f <= w_res_f;
            end
        end
    end

    // Credits reserve a slot at acceptance, so the stage-2 write never finds
    // the FIFO full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_y[i] <= '0;
                r_mem_f[i] <= '0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_occ <= '0;
        end else begin
            if (r_s2_v) begin
                r_mem_y[r_wr] <= r_s2_y;
                r_mem_f[r_wr] <= r_s2_f;
                r_wr          <= f_nxt(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_nxt(r_rd);
            end
            case ({r_s2_v, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            case ({w_acc, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_expr_lane_pipe.sv
// Testbench for expr_lane_pipe: random and directed beats checked against a
// queue-based reference model that computes lane results with integer math.
module tb_expr_lane_pipe;

    localparam int W     = 6;
    localparam int LANES = 6;
    localparam int DEPTH = 4;
    localparam int LW    = W * LANES;
    localparam int OW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_op = '0;
    logic [LANES-1:0]  in_sign = '0;
    logic [LW-1:0]     in_a = '0;
    logic [LW-1:0]     in_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LW-1:0]     out_y;
    logic [LANES-1:0]  out_flag;
    logic [OW-1:0]     occupancy;

    always #5 clk = ~clk;

    expr_lane_pipe #(.W(W), .LANES(LANES), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_sign   (in_sign),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flag  (out_flag),
        .occupancy (occupancy)
    );

    typedef struct {
        logic [LW-1:0]    y;
        logic [LANES-1:0] f;
        int               t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_dut_acc = 0;
    int   n_dut_pop = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void ref_lane(input int op, input bit s, input int a, input int b,
                                     output int y, output bit f);
        int     m;
        int     sa;
        int     sb;
        int     r;
        int     amt;
        longint p;
        m   = 1 << W;
        sa  = (s && a >= m / 2) ? a - m : a;
        sb  = (s && b >= m / 2) ? b - m : b;
        amt = b % (1 << $clog2(W));
        y   = 0;
        f   = 1'b0;
        case (op)
            0: begin
                r = sa + sb;
                y = r & (m - 1);
                f = s ? (r < -m / 2 || r >= m / 2) : (r >= m);
            end
            1: begin
                r = sa - sb;
                y = r & (m - 1);
                f = s ? (r < -m / 2 || r >= m / 2) : (a < b);
            end
            2: begin
                y = a & b;
                f = (y == 0);
            end
            3: begin
                y = ~(a ^ b) & (m - 1);
                f = (y == 0);
            end
            4: begin
                if (amt >= W) begin
                    y = 0;
                    f = (a != 0);
                end else begin
                    r = a << amt;
                    y = r & (m - 1);
                    f = (r >= m);
                end
            end
            5: begin
                if (amt >= W) y = (s && sa < 0) ? m - 1 : 0;
                else if (s)   y = (sa >>> amt) & (m - 1);
                else          y = a >> amt;
                f = (y == 0);
            end
            6: begin
                if (s) y = (sa <= sb) ? 1 : 0;
                else   y = (a <= b) ? 1 : 0;
                f = (a == b);
            end
            default: begin
                p = longint'(sa) * longint'(sb);
                y = int'(p & longint'(m - 1));
                f = s ? (p < -m / 2 || p >= m / 2) : (p >= m);
            end
        endcase
    endfunction

    function automatic void ref_beat(input logic [2:0] op, input logic [LANES-1:0] s,
                                     input logic [LW-1:0] a, input logic [LW-1:0] b,
                                     output logic [LW-1:0] y, output logic [LANES-1:0] f);
        int yl;
        bit fl;
        y = '0;
        f = '0;
        for (int i = 0; i < LANES; i++) begin
            ref_lane(int'(op), s[i], int'(a[i*W +: W]), int'(b[i*W +: W]), yl, fl);
            y[i*W +: W] = W'(yl);
            f[i]        = fl;
        end
    endfunction

    task automatic model_check();
        bit vis;
        vis = (q.size() > 0) && (q[0].t <= cyc);
        chk("in_ready", in_ready, (q.size() < DEPTH));
        chk("occupancy", occupancy, q.size());
        chk("out_valid", out_valid, vis);
        if (vis) begin
            chk("out_y", out_y, q[0].y);
            chk("out_flag", out_flag, q[0].f);
        end
    endtask

    // One clock: predict handshakes from the model, advance, then compare.
    task automatic step();
        bit               acc;
        bit               pop;
        logic [LW-1:0]    ey;
        logic [LANES-1:0] ef;
        exp_t             e;
        acc = in_valid && (q.size() < DEPTH);
        pop = out_ready && (q.size() > 0) && (q[0].t <= cyc);
        if (in_valid && in_ready)   n_dut_acc++;
        if (out_valid && out_ready) n_dut_pop++;
        ey = '0;
        ef = '0;
        if (acc) ref_beat(in_op, in_sign, in_a, in_b, ey, ef);
        @(posedge clk);
        cyc++;
        if (pop) q.delete(0);
        if (acc) begin
            e.y = ey;
            e.f = ef;
            e.t = cyc + 2;
            q.push_back(e);
        end
        #2;
        model_check();
    endtask

    task automatic rand_beat();
        in_op   = 3'($urandom_range(0, 7));
        in_sign = LANES'($urandom);
        in_a    = LW'({$urandom, $urandom});
        in_b    = LW'({$urandom, $urandom});
    endtask

    task automatic clear_beat();
        in_a    = '0;
        in_b    = '0;
        in_sign = '0;
    endtask

    task automatic set_lane(input int i, input int a, input int b, input bit s);
        in_a[i*W +: W] = W'(a);
        in_b[i*W +: W] = W'(b);
        in_sign[i]     = s;
    endtask

    task automatic chk_out(input string tag, input int y0, input int y1, input int y2,
                           input int y3, input int y4, input int y5, input int fl);
        logic [LW-1:0] v;
        v = '0;
        v[0*W +: W] = W'(y0);
        v[1*W +: W] = W'(y1);
        v[2*W +: W] = W'(y2);
        v[3*W +: W] = W'(y3);
        v[4*W +: W] = W'(y4);
        v[5*W +: W] = W'(y5);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_y"}, out_y, v);
        chk({tag, "_flag"}, out_flag, fl);
    endtask

    // Present the prepared beat for one edge, then look two edges later.
    task automatic run_directed();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_y", out_y, 0);
        chk("reset_out_flag", out_flag, 0);
        chk("reset_occupancy", occupancy, 0);
        rst_n = 1'b1;

        // add: signed overflow, carry-out, plain sum
        clear_beat();
        in_op = 3'd0;
        set_lane(0, 31, 1, 1'b1);
        set_lane(1, 63, 1, 1'b0);
        set_lane(2, 5, 2, 1'b1);
        run_directed();
        chk_out("add", 'h20, 'h00, 7, 0, 0, 0, 'h03);

        // shr: arithmetic/logical, and amounts >= W
        clear_beat();
        in_op = 3'd5;
        set_lane(0, 'h30, 2, 1'b1);
        set_lane(1, 'h30, 2, 1'b0);
        set_lane(2, 'h30, 7, 1'b1);
        set_lane(3, 'h30, 7, 1'b0);
        run_directed();
        chk_out("shr", 'h3C, 'h0C, 'h3F, 'h00, 0, 0, 'h38);

        // le: signed vs unsigned comparison
        clear_beat();
        in_op = 3'd6;
        set_lane(0, 'h3F, 1, 1'b1);
        set_lane(1, 'h3F, 1, 1'b0);
        run_directed();
        chk_out("le", 1, 0, 1, 1, 1, 1, 'h3C);

        // mul: signed -1*-1 and unsigned 63*63
        clear_beat();
        in_op = 3'd7;
        set_lane(0, 'h3F, 'h3F, 1'b1);
        set_lane(1, 'h3F, 'h3F, 1'b0);
        run_directed();
        chk_out("mul", 1, 1, 0, 0, 0, 0, 'h02);

        repeat (4) step();

        // Backpressure: five beats offered, four accepted.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_beat();
            in_valid = 1'b1;
            step();
            if (i == 3) begin
                chk("bp_occupancy", occupancy, 4);
                chk("bp_in_ready", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        step();
        chk("bp_ready_after_pop", in_ready, 1);
        repeat (6) step();

        // Full FIFO with both sides held active.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            in_valid = 1'b1;
            step();
        end
        out_ready = 1'b1;
        n_dut_acc = 0;
        n_dut_pop = 0;
        for (int i = 0; i < 10; i++) begin
            rand_beat();
            step();
        end
        chk("sustain_pops", n_dut_pop, 10);
        chk("sustain_accepts", n_dut_acc, 9);
        in_valid = 1'b0;
        repeat (8) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        // Reset with three beats buffered and one in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("pre_reset_valid", out_valid, 1);
        rand_beat();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_y", out_y, 0);
        q.delete();
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 60; i++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
